// File: rtl/hm_pkg.sv
// Shared FSM state type and beat/word count helpers for the homomorphic multiply controller.
package hm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    DRAIN  = 2'd3
  } hm_state_e;

  // Load beats per ciphertext: ceil((dimension+1)/parallel)
  function automatic int nb_f(input int dimension, input int parallel);
    return (dimension + parallel) / parallel;
  endfunction

  function automatic int rw_f(input int dimension);
    return 2 * dimension + 1;
  endfunction

  function automatic int rb_f(input int dimension, input int parallel);
    return (rw_f(dimension) + parallel - 1) / parallel;
  endfunction

endpackage

// File: rtl/hm_result_fifo.sv
// Two-entry result FIFO between the multiplier and the result stream.
// Simultaneous push and pop are accepted even when full; flush empties it at once.
module hm_result_fifo #(
  parameter int WIDTH = 42
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != 2'd0);
    push_ok  = push && ((count_q != 2'd2) || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      mem_d[0] = '0;
      mem_d[1] = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (count_q != 2'd0);
  assign count     = count_q;

endmodule

// File: rtl/homomorphic_multiply_ctrl.sv
// Sequences operand loads into the homomorphic multiplier and streams its partial results out.
// Optional HM_CTRL_ABORT_EN adds an abort input that drops the current job without a done pulse.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_A | accepting ciphertext 1 beats, no results produced
// LOAD_B | accepting ciphertext 2 beats, each issue yields a result
// DRAIN  | issuing remaining result rows and emptying the FIFO
module homomorphic_multiply_ctrl
  import hm_pkg::*;
#(
  parameter int DIMENSION        = 3,
  parameter int DIM_WIDTH        = 2,
  parameter int CIPHERTEXT_WIDTH = 21,
  parameter int PARALLEL         = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
`ifdef HM_CTRL_ABORT_EN
  input  logic                                 abort,
`endif
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] out_data,
  output logic [PARALLEL-1:0]                  out_keep,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] hm_op1,
  output logic [DIM_WIDTH:0]                   hm_row,
  output logic                                 hm_ciphertext_select,
  output logic                                 hm_en,
  input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] hm_result
);

  localparam int DW         = PARALLEL * CIPHERTEXT_WIDTH;
  localparam int ROW_W      = DIM_WIDTH + 1;
  localparam int NB         = nb_f(DIMENSION, PARALLEL);
  localparam int RW         = rw_f(DIMENSION);
  localparam int RB         = rb_f(DIMENSION, PARALLEL);
  localparam int CNT_W      = $clog2(RB + 1);
  localparam int LAST_LANES = RW - (RB - 1) * PARALLEL;
  localparam logic [PARALLEL-1:0] LAST_KEEP = {PARALLEL{1'b1}} >> (PARALLEL - LAST_LANES);

  localparam logic [CNT_W-1:0] NB_LAST = CNT_W'(NB - 1);
  localparam logic [CNT_W-1:0] NB_CNT  = CNT_W'(NB);
  localparam logic [CNT_W-1:0] RB_CNT  = CNT_W'(RB);
  localparam logic [CNT_W-1:0] RB_LAST = CNT_W'(RB - 1);

  hm_state_e        state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             inflight_q, inflight_d;
  logic             done_q, done_d;

  logic             abort_hit;
  logic             in_ready_c;
  logic             issue, result_issue, issue_sel;
  logic [DW-1:0]    issue_op;
  logic [1:0]       fifo_count;
  logic             fifo_ne;
  logic [DW-1:0]    fifo_head;
  logic             credit_ok;
  logic             pop;

`ifdef HM_CTRL_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // The FIFO slot for an in-flight result is reserved at issue time.
  assign credit_ok = (fifo_count + {1'b0, inflight_q}) < 2'd2;
  assign pop       = fifo_ne && out_ready;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    out_cnt_d    = out_cnt_q;
    done_d       = 1'b0;
    in_ready_c   = 1'b0;
    issue        = 1'b0;
    result_issue = 1'b0;
    issue_sel    = 1'b0;
    issue_op     = '0;
    if (pop) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD_A;
          beat_d    = '0;
          out_cnt_d = '0;
        end
      end
      LOAD_A: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          issue    = 1'b1;
          issue_op = in_data;
          if (beat_q == NB_LAST) begin
            state_d = LOAD_B;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      LOAD_B: begin
        in_ready_c = credit_ok;
        if (in_valid && credit_ok) begin
          issue        = 1'b1;
          result_issue = 1'b1;
          issue_sel    = 1'b1;
          issue_op     = in_data;
          if (beat_q == NB_LAST) begin
            state_d = DRAIN;
            beat_d  = NB_CNT;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if ((beat_q < RB_CNT) && credit_ok) begin
          issue        = 1'b1;
          result_issue = 1'b1;
          beat_d       = beat_q + CNT_W'(1);
        end
        if (pop && (out_cnt_q == RB_LAST)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d = result_issue;
    if (abort_hit) begin
      state_d    = IDLE;
      beat_d     = '0;
      out_cnt_d  = '0;
      inflight_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  hm_result_fifo #(
    .WIDTH(DW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort_hit),
    .push     (inflight_q),
    .push_data(hm_result),
    .pop      (pop),
    .head     (fifo_head),
    .not_empty(fifo_ne),
    .count    (fifo_count)
  );

  assign busy                 = (state_q != IDLE);
  assign done                 = done_q;
  assign in_ready             = in_ready_c;
  assign hm_en                = issue;
  assign hm_op1               = issue_op;
  assign hm_ciphertext_select = issue_sel;
  assign hm_row               = issue ? ROW_W'(int'(beat_q) * PARALLEL) : '0;

  assign out_valid = fifo_ne;
  assign out_data  = fifo_ne ? fifo_head : '0;
  assign out_last  = fifo_ne && (out_cnt_q == RB_LAST);
  assign out_keep  = !fifo_ne ? '0 : ((out_cnt_q == RB_LAST) ? LAST_KEEP : {PARALLEL{1'b1}});

endmodule

// File: tb/tb_homomorphic_multiply_ctrl.sv
// Scoreboard bench for homomorphic_multiply_ctrl (DIMENSION=3, PARALLEL=2) with a behavioural multiplier.
module tb_homomorphic_multiply_ctrl;

  localparam int CW = 21;
  localparam int P  = 2;
  localparam int DW = P * CW;

  localparam int M_BASIC = 0;
  localparam int M_STALL = 1;
  localparam int M_BP    = 2;
  localparam int M_BUSY  = 3;
  localparam int M_RST   = 4;
  localparam int M_ABORT = 5;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready;
  logic [DW-1:0] in_data, hm_result;
  logic          busy, done, in_ready, out_last, out_valid, hm_en, hm_ciphertext_select;
  logic [DW-1:0] out_data, hm_op1;
  logic [P-1:0]  out_keep;
  logic [2:0]    hm_row;
`ifdef HM_CTRL_ABORT_EN
  logic          abort;
`endif

  homomorphic_multiply_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef HM_CTRL_ABORT_EN
    .abort(abort),
`endif
    .start(start), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .hm_op1(hm_op1), .hm_row(hm_row), .hm_ciphertext_select(hm_ciphertext_select),
    .hm_en(hm_en), .hm_result(hm_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] op; logic [2:0] row; logic sel; } iss_t;
  typedef struct { logic [DW-1:0] data; logic [P-1:0] keep; logic last; } res_t;

  iss_t iss_q[$];
  res_t res_q[$];
  res_t exp_tab[2][4];

  int checks = 0;
  int errors = 0;

  int unsigned cur_a[4];
  int unsigned cur_b[4];

  bit chk_en    = 1'b0;
  bit stall_chk = 1'b0;
  int pops = 0, res_iss = 0, done_cnt = 0;
  int last_pop_cyc = -10, first_b_cyc = -1, first_ov_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pk(input int unsigned l0, input int unsigned l1);
    return {CW'(l1), CW'(l0)};
  endfunction

  function automatic logic [CW-1:0] conv(input int r);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      if ((r - i >= 0) && (r - i < 4)) s += cur_a[i] * cur_b[r - i];
    end
    return CW'(s);
  endfunction

  // Multiplier stand-in: result words row and row+1, one cycle after a result-producing issue.
  always @(posedge clk) begin
    if (hm_en && (hm_ciphertext_select || hm_row >= 3'd4))
      hm_result <= {conv(int'(hm_row) + 1), conv(int'(hm_row))};
    else
      hm_result <= {10'($urandom()), $urandom()};
  end

  // Monitor: compares issues and result beats against the scoreboard queues.
  always @(negedge clk) begin
    iss_t e;
    res_t r;
    logic [DW-1:0] m;
    if (chk_en) begin
      if (hm_en) begin
        if (iss_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got row %0d sel %0d, required no issue", hm_row, hm_ciphertext_select);
        end else begin
          e = iss_q.pop_front();
          chk("hm_row", 64'(hm_row), 64'(e.row));
          chk("hm_sel", 64'(hm_ciphertext_select), 64'(e.sel));
          chk("hm_op1", 64'(hm_op1), 64'(e.op));
        end
        if (hm_ciphertext_select || hm_row >= 3'd4) begin
          res_iss++;
          chk("outstanding_le_2", 64'(res_iss - pops <= 2), 64'd1);
        end
        if (hm_ciphertext_select && first_b_cyc < 0) first_b_cyc = cyc;
      end
      if (stall_chk) chk("stall_hm_en", 64'(hm_en), 64'd0);
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (out_valid && out_ready) begin
        pops++;
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got data %0h, required no beat", out_data);
        end else begin
          r = res_q.pop_front();
          m = {{CW{r.keep[1]}}, {CW{r.keep[0]}}};
          chk("out_keep", 64'(out_keep), 64'(r.keep));
          chk("out_last", 64'(out_last), 64'(r.last));
          chk("out_data", 64'(out_data & m), 64'(r.data & m));
        end
        if (out_last) last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", 64'(cyc), 64'(last_pop_cyc + 1));
        chk("done_idle", 64'(busy), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    chk("in_accept_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic stall_cycle(input bit expect_idle);
    stall_chk = expect_idle;
    tick();
    stall_chk = 1'b0;
  endtask

  task automatic set_vec(input int vid);
    if (vid == 0) begin
      cur_a = '{1, 1, 1, 1};
      cur_b = '{1, 1, 1, 1};
    end else begin
      cur_a = '{1, 2, 3, 4};
      cur_b = '{1, 0, 0, 1};
    end
  endtask

  task automatic run_job(input int mode, input int vid);
    int d0, p0;
    bit seen;
    set_vec(vid);
    for (int k = 0; k < 4; k++) res_q.push_back(exp_tab[vid][k]);
    iss_q.push_back('{pk(cur_a[0], cur_a[1]), 3'd0, 1'b0});
    iss_q.push_back('{pk(cur_a[2], cur_a[3]), 3'd2, 1'b0});
    iss_q.push_back('{pk(cur_b[0], cur_b[1]), 3'd0, 1'b1});
    iss_q.push_back('{pk(cur_b[2], cur_b[3]), 3'd2, 1'b1});
    iss_q.push_back('{'0, 3'd4, 1'b0});
    iss_q.push_back('{'0, 3'd6, 1'b0});
    d0 = done_cnt;
    p0 = pops;
    first_b_cyc  = -1;
    first_ov_cyc = -1;
    out_ready = (mode != M_BP);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beat(pk(cur_a[0], cur_a[1]));
    if (mode == M_STALL) stall_cycle(1'b1);
    send_beat(pk(cur_a[2], cur_a[3]));
    if (mode == M_STALL) stall_cycle(1'b1);
    if (mode == M_BUSY) start = 1'b1;
    send_beat(pk(cur_b[0], cur_b[1]));
    start = 1'b0;
    if (mode == M_STALL) stall_cycle(1'b1);
    send_beat(pk(cur_b[2], cur_b[3]));
    if (mode == M_BP) begin
      seen = out_valid;
      for (int n = 0; n < 50 && !seen; n++) begin
        tick();
        seen = out_valid;
      end
      chk("bp_first_valid_timeout", 64'(seen), 64'd1);
      repeat (5) tick();
      out_ready = 1'b1;
    end
    if (mode == M_RST || mode == M_ABORT) begin
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
        tick();
        seen = (pops - p0 >= 1);
      end
      chk("mid_drain_timeout", 64'(seen), 64'd1);
      chk_en = 1'b0;
`ifdef HM_CTRL_ABORT_EN
      if (mode == M_ABORT) abort = 1'b1;
      else rst = 1'b1;
`else
      rst = 1'b1;
`endif
      tick();
      rst = 1'b0;
`ifdef HM_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      @(negedge clk);
      chk("cut_ctrl_zero", 64'({busy, done, in_ready, out_valid, out_last, out_keep, hm_en, hm_ciphertext_select, hm_row}), 64'd0);
      chk("cut_data_zero", 64'(out_data | hm_op1), 64'd0);
      iss_q.delete();
      res_q.delete();
      pops    = 0;
      res_iss = 0;
      chk_en  = 1'b1;
      repeat (6) tick();
      chk("cut_no_done", 64'(done_cnt - d0), 64'd0);
      chk("cut_idle", 64'(busy), 64'd0);
    end else begin
      seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
        tick();
        seen = (done_cnt > d0);
      end
      chk("done_timeout", 64'(seen), 64'd1);
      repeat (3) tick();
      chk("done_count", 64'(done_cnt - d0), 64'd1);
      chk("issues_left", 64'(iss_q.size()), 64'd0);
      chk("beats_left", 64'(res_q.size()), 64'd0);
      chk("busy_after", 64'(busy), 64'd0);
      if (mode == M_BASIC) chk("latency_b_to_valid", 64'(first_ov_cyc - first_b_cyc), 64'd2);
    end
  endtask

  initial begin
    exp_tab[0][0] = '{pk(1, 2), 2'b11, 1'b0};
    exp_tab[0][1] = '{pk(3, 4), 2'b11, 1'b0};
    exp_tab[0][2] = '{pk(3, 2), 2'b11, 1'b0};
    exp_tab[0][3] = '{pk(1, 0), 2'b01, 1'b1};
    exp_tab[1][0] = '{pk(1, 2), 2'b11, 1'b0};
    exp_tab[1][1] = '{pk(3, 5), 2'b11, 1'b0};
    exp_tab[1][2] = '{pk(2, 3), 2'b11, 1'b0};
    exp_tab[1][3] = '{pk(4, 0), 2'b01, 1'b1};
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef HM_CTRL_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (3) tick();
    @(negedge clk);
    chk("reset_ctrl", 64'({busy, done, in_ready, out_valid, out_last, out_keep, hm_en, hm_ciphertext_select, hm_row}), 64'd0);
    chk("reset_data", 64'(out_data | hm_op1), 64'd0);
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    tick();
    run_job(M_BASIC, 0);
    run_job(M_BASIC, 1);
    run_job(M_BP, 0);
    run_job(M_STALL, 0);
    run_job(M_BUSY, 1);
    run_job(M_RST, 1);
    run_job(M_BASIC, 0);
`ifdef HM_CTRL_ABORT_EN
    run_job(M_ABORT, 1);
    run_job(M_BASIC, 0);
`endif
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
